// File: rtl/vslc_pkg.sv
// -----------------------------------------------------------------------------
// vslc_pkg
// Shared constants and types for the VSLC input path.
//   VSLC_IO_W              : width of the ui_in image seen by the scan core
//   VSLC_DEBOUNCE_DEFAULT  : default number of consecutive disagreeing scans
//                            needed before a debounced bit flips
//   vslc_cnt_w()           : width of a per-bit debounce counter; also used by
//                            the core when it sizes its ui_in_reg logic
//   db_action_e            : per-bit update decision taken on each scan edge
// -----------------------------------------------------------------------------
package vslc_pkg;

   localparam int VSLC_IO_W             = 8;
   localparam int VSLC_DEBOUNCE_DEFAULT = 3;

   // Counter only has to reach DEBOUNCE_SCANS-1, so $clog2 is exact;
   // a single scan of debounce still gets a 1-bit counter to keep ports legal.
   function automatic int vslc_cnt_w(input int debounce_scans);
      int w;
      w = (debounce_scans <= 1) ? 1 : $clog2(debounce_scans);
      return (w < 1) ? 1 : w;
   endfunction

   // What a debounce cell does with its state on the current scan edge.
   typedef enum logic [1:0] {
      DB_AGREE = 2'd0,   // synced sample matches state: drop any pending count
      DB_COUNT = 2'd1,   // disagreement seen, not yet long enough: count it
      DB_FLIP  = 2'd2,   // disagreement held for the full window: take sample
      DB_FORCE = 2'd3    // bit is bypassed: take sample directly
   } db_action_e;

endpackage

// File: rtl/vslc_debounce_bit.sv
// -----------------------------------------------------------------------------
// vslc_debounce_bit
// One bit of the input conditioner: second synchroniser stage, debounce
// counter, debounced state flop and previous-scan flop.
// Ports:
//   scan_cycle_clk  in   scan clock, one posedge per program pass
//   rst_n           in   synchronous active-low reset
//   sync1_bit       in   first synchroniser stage output for this bit
//   bypass          in   1 = state follows the synced sample directly
//   state           out  debounced current value
//   prev            out  state as it was on the previous scan
// -----------------------------------------------------------------------------
module vslc_debounce_bit
   import vslc_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = VSLC_DEBOUNCE_DEFAULT
) (
   input  logic scan_cycle_clk,
   input  logic rst_n,
   input  logic sync1_bit,
   input  logic bypass,
   output logic state,
   output logic prev
);

   localparam int                CNT_W    = vslc_cnt_w(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   logic             sync2_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             state_reg;
   logic             state_next;
   logic             prev_reg;
   db_action_e       action;

   // Decide what this edge does. Bypass has priority so a pending count is
   // discarded on the very first bypassed edge.
   always_comb begin
      action = DB_AGREE;
      if (bypass) begin
         action = DB_FORCE;
      end else if (sync2_reg == state_reg) begin
         action = DB_AGREE;
      end else if (cnt_reg == CNT_LAST) begin
         action = DB_FLIP;
      end else begin
         action = DB_COUNT;
      end
   end

   always_comb begin
      cnt_next   = '0;
      state_next = state_reg;
      case (action)
         DB_AGREE: begin
            cnt_next   = '0;
            state_next = state_reg;
         end
         DB_COUNT: begin
            // Cannot wrap: DB_FLIP is taken once cnt reaches CNT_LAST.
            cnt_next   = cnt_reg + CNT_W'(1);
            state_next = state_reg;
         end
         DB_FLIP: begin
            cnt_next   = '0;
            state_next = sync2_reg;
         end
         DB_FORCE: begin
            cnt_next   = '0;
            state_next = sync2_reg;
         end
         default: begin
            cnt_next   = '0;
            state_next = state_reg;
         end
      endcase
   end

   always_ff @(posedge scan_cycle_clk) begin
      if (!rst_n) begin
         sync2_reg <= 1'b0;
         cnt_reg   <= '0;
         state_reg <= 1'b0;
         prev_reg  <= 1'b0;
      end else begin
         sync2_reg <= sync1_bit;
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
         // prev tracks state unconditionally, so bypass changes never touch it.
         prev_reg  <= state_reg;
      end
   end

   assign state = state_reg;
   assign prev  = prev_reg;

endmodule

// File: rtl/vslc_input_conditioner.sv
// -----------------------------------------------------------------------------
// vslc_input_conditioner
// Input-image stage for the VSLC scan engine. Synchronises the raw ui_in pins,
// debounces each bit over DEBOUNCE_SCANS scans and presents the current and
// previous-scan images plus per-bit edge flags. Advances once per scan so the
// core sees a stable image for a whole program pass.
// Optional feature macro: VSLC_INPUT_LATCH_EN (sticky rise capture).
// Ports:
//   scan_cycle_clk  in   scan clock, one posedge per program pass
//   rst_n           in   synchronous active-low reset
//   raw_in          in   asynchronous pin inputs
//   bypass_mask     in   1 = bit skips debounce
//   clr_latch       in   clear latched_rise (only with VSLC_INPUT_LATCH_EN)
//   in_state        out  debounced current image
//   in_prev         out  in_state of the previous scan
//   rise            out  in_state & ~in_prev
//   fall            out  ~in_state & in_prev
//   latched_rise    out  sticky rise capture (0 without VSLC_INPUT_LATCH_EN)
// -----------------------------------------------------------------------------
module vslc_input_conditioner
   import vslc_pkg::*;
#(
   parameter int WIDTH          = VSLC_IO_W,
   parameter int DEBOUNCE_SCANS = VSLC_DEBOUNCE_DEFAULT
) (
   input  logic             scan_cycle_clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   input  logic [WIDTH-1:0] bypass_mask,
   input  logic             clr_latch,
   output logic [WIDTH-1:0] in_state,
   output logic [WIDTH-1:0] in_prev,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] latched_rise
);

   // First synchroniser stage; the second lives in each debounce cell.
   logic [WIDTH-1:0] sync1_reg;

   always_ff @(posedge scan_cycle_clk) begin
      if (!rst_n) begin
         sync1_reg <= '0;
      end else begin
         sync1_reg <= raw_in;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         vslc_debounce_bit #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
         ) u_bit (
            .scan_cycle_clk (scan_cycle_clk),
            .rst_n          (rst_n),
            .sync1_bit      (sync1_reg[gi]),
            .bypass         (bypass_mask[gi]),
            .state          (in_state[gi]),
            .prev           (in_prev[gi])
         );
      end
   endgenerate

   // Both come straight from flops, so each pulse spans exactly one scan.
   assign rise = in_state & ~in_prev;
   assign fall = ~in_state & in_prev;

`ifdef VSLC_INPUT_LATCH_EN
   logic [WIDTH-1:0] latched_rise_reg;

   // Set wins over clear so an edge arriving on the clearing scan is kept.
   always_ff @(posedge scan_cycle_clk) begin
      if (!rst_n) begin
         latched_rise_reg <= '0;
      end else begin
         latched_rise_reg <= (latched_rise_reg & ~{WIDTH{clr_latch}}) | rise;
      end
   end

   assign latched_rise = latched_rise_reg;
`else
   logic _unused;
   assign _unused      = &{1'b0, clr_latch};
   assign latched_rise = '0;
`endif

endmodule

// File: tb/tb_vslc_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_vslc_input_conditioner
// Scoreboard bench: the stimulus process drives inputs each scan, advances a
// behavioural model and queues the expected post-edge outputs; the monitor
// pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_vslc_input_conditioner;

   localparam int W = 8;
   localparam int D = 3;

   logic         scan_cycle_clk;
   logic         rst_n;
   logic [W-1:0] raw_in;
   logic [W-1:0] bypass_mask;
   logic         clr_latch;
   logic [W-1:0] in_state;
   logic [W-1:0] in_prev;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic [W-1:0] latched_rise;

   vslc_input_conditioner #(
      .WIDTH          (W),
      .DEBOUNCE_SCANS (D)
   ) dut (
      .scan_cycle_clk (scan_cycle_clk),
      .rst_n          (rst_n),
      .raw_in         (raw_in),
      .bypass_mask    (bypass_mask),
      .clr_latch      (clr_latch),
      .in_state       (in_state),
      .in_prev        (in_prev),
      .rise           (rise),
      .fall           (fall),
      .latched_rise   (latched_rise)
   );

   initial scan_cycle_clk = 1'b0;
   always #5 scan_cycle_clk = ~scan_cycle_clk;

   typedef struct packed {
      logic [W-1:0] st;
      logic [W-1:0] pv;
      logic [W-1:0] ri;
      logic [W-1:0] fa;
      logic [W-1:0] la;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   mon_edge = 0;

   // ---------------- behavioural model ----------------
   // A bit follows its synced sample once that sample has disagreed with it
   // on D consecutive non-bypassed scans; the run start is remembered by scan
   // number rather than counted.
   logic [W-1:0] m_pipe1, m_pipe2, m_state, m_prev, m_latch;
   int           run_start [W];
   int           scan_no = 0;

   task automatic model_reset();
      m_pipe1 = '0; m_pipe2 = '0; m_state = '0; m_prev = '0; m_latch = '0;
      for (int i = 0; i < W; i++) run_start[i] = -1;
   endtask

   task automatic model_scan(input logic [W-1:0] r, input logic [W-1:0] b,
                             input logic c, input logic rn);
      logic [W-1:0] rise_now, nxt, seen;
      scan_no++;
      rise_now = m_state & ~m_prev;
      if (!rn) begin
         model_reset();
      end else begin
         seen = m_pipe2;                       // sample two scans old
         nxt  = m_state;
         for (int i = 0; i < W; i++) begin
            if (b[i]) begin
               nxt[i] = seen[i];
               run_start[i] = -1;
            end else if (seen[i] == m_state[i]) begin
               run_start[i] = -1;
            end else begin
               if (run_start[i] < 0) run_start[i] = scan_no;
               if (scan_no - run_start[i] + 1 >= D) begin
                  nxt[i] = seen[i];
                  run_start[i] = -1;
               end
            end
         end
         m_prev  = m_state;
         m_state = nxt;
         m_pipe2 = m_pipe1;
         m_pipe1 = r;
`ifdef VSLC_INPUT_LATCH_EN
         m_latch = (c ? '0 : m_latch) | rise_now;
`else
         m_latch = '0;
`endif
      end
   endtask

   // One scan of stimulus: drive away from the rising edge, then queue what
   // the outputs must show after that edge.
   task automatic step(input logic [W-1:0] r, input logic [W-1:0] b,
                       input logic c, input logic rn);
      exp_t e;
      @(negedge scan_cycle_clk);
      raw_in = r; bypass_mask = b; clr_latch = c; rst_n = rn;
      model_scan(r, b, c, rn);
      e.st = m_state;
      e.pv = m_prev;
      e.ri = m_state & ~m_prev;
      e.fa = ~m_state & m_prev;
      e.la = m_latch;
      q.push_back(e);
   endtask

   task automatic steps(input int n, input logic [W-1:0] r,
                        input logic [W-1:0] b, input logic c, input logic rn);
      for (int k = 0; k < n; k++) step(r, b, c, rn);
   endtask

   // ---------------- monitor ----------------
   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s scan=%0d got=%02h want=%02h", name, mon_edge, act, exp_v);
      end
   endtask

   initial begin
      exp_t e;
      @(negedge scan_cycle_clk);
      forever begin
         @(posedge scan_cycle_clk);
         #1;
         mon_edge++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty scan=%0d got=0 want=1", mon_edge);
         end else begin
            e = q.pop_front();
            chk("in_state", in_state, e.st);
            chk("in_prev", in_prev, e.pv);
            chk("rise", rise, e.ri);
            chk("fall", fall, e.fa);
            chk("latched_rise", latched_rise, e.la);
            $display("scan %0d raw=%02h byp=%02h st=%02h pv=%02h ri=%02h fa=%02h la=%02h",
                     mon_edge, raw_in, bypass_mask, in_state, in_prev, rise, fall,
                     latched_rise);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] cur_raw, cur_byp;
      logic         c, rn;
      rst_n = 1'b0; raw_in = 8'hFF; bypass_mask = '0; clr_latch = 1'b0;
      model_reset();

      // Input high through reset, then the deliberate rise after debounce.
      steps(3, 8'hFF, 8'h00, 1'b0, 1'b0);
      steps(8, 8'hFF, 8'h00, 1'b0, 1'b1);
      // Fall everything, then a 2-scan glitch on bit0 that must be rejected.
      steps(8, 8'h00, 8'h00, 1'b0, 1'b1);
      steps(2, 8'h01, 8'h00, 1'b0, 1'b1);
      steps(6, 8'h00, 8'h00, 1'b0, 1'b1);
      // Bit0 bypassed, bit1 debounced, toggled together.
      steps(6, 8'h03, 8'h01, 1'b0, 1'b1);
      steps(6, 8'h00, 8'h01, 1'b0, 1'b1);
      // Build 0F, then release it and watch fall/prev.
      steps(8, 8'h0F, 8'h00, 1'b0, 1'b1);
      steps(8, 8'h00, 8'h00, 1'b0, 1'b1);
      // Bit3 part-way through its count, reset for one scan, count again.
      steps(4, 8'h08, 8'h00, 1'b0, 1'b1);
      steps(1, 8'h08, 8'h00, 1'b0, 1'b0);
      steps(8, 8'h08, 8'h00, 1'b0, 1'b1);
      // Bit5 rise arriving while clr_latch is held, then clear it.
      steps(4, 8'h00, 8'h00, 1'b0, 1'b1);
      steps(7, 8'h20, 8'h00, 1'b1, 1'b1);
      steps(2, 8'h20, 8'h00, 1'b0, 1'b1);
      steps(1, 8'h20, 8'h00, 1'b1, 1'b1);
      steps(2, 8'h20, 8'h00, 1'b0, 1'b1);
      // A pending count dropped by bypass.
      steps(2, 8'h00, 8'h00, 1'b0, 1'b1);
      steps(1, 8'h00, 8'h20, 1'b0, 1'b1);
      steps(6, 8'h00, 8'h00, 1'b0, 1'b1);

      // Randomised slow-changing inputs with occasional glitches, bypass
      // changes, latch clears and resets.
      cur_raw = '0;
      cur_byp = '0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0)
            cur_raw = cur_raw ^ W'($urandom & $urandom);
         if ($urandom_range(0, 39) == 0)
            cur_byp = W'($urandom & $urandom);
         c  = ($urandom_range(0, 7) == 0);
         rn = ($urandom_range(0, 99) != 0);
         step(cur_raw, cur_byp, c, rn);
      end

      @(posedge scan_cycle_clk);
      #3;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
